apb_ram_wait: RTL and testbench

- Parametrised APB4 slave RAM. Successor to the fixed 32x32 APB RAM used as the testbench target in this codebase.
- Adds configurable data width, depth and address width, per-byte write strobes (pstrb), and a programmable number of wait states.
- Flags errors with pslverr for out-of-range and misaligned addresses.
- Sits on the APB bus as a memory-mapped scratch RAM; it is the DUT for the class-based APB verification environment.

---
 rtl/apb_ram_pkg.sv | 25 ++
 rtl/apb_ram_mem.sv | 57 +++++
 rtl/apb_ram_wait.sv | 183 ++++++++++++++++++
 tb/tb_apb_ram_wait.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ram_pkg
//  Purpose  : Shared types and helpers for the wait-state APB scratch RAM.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_ram_pkg;

  // Largest supported number of inserted access-phase wait states
  localparam int MAX_WAIT = 15;

  // Transfer-tracking states of the slave
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  // Number of byte-offset address bits below the word index
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_ram_mem.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ram_mem
//  Purpose  : DEPTH x DATA_WIDTH word storage with asynchronous clear, a
//             byte-enabled write port and a registered read port.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int IDX_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
  input  logic                    i_rd_en,
  input  logic [IDX_W-1:0]        i_rd_idx,
  input  logic                    i_rd_zero,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  localparam int c_nb = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage: cleared on reset, otherwise updated lane by lane under the strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int b = 0; b < c_nb; b++) begin
        if (i_wr_strb[b]) begin
          r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads a word (or zero for a faulted access) and holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/apb_ram_wait.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ram_wait
//  Purpose  : Parametrised APB4 slave RAM with byte strobes, programmable
//             access-phase wait states and pslverr on bad addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_ram_wait
  import apb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int                    c_lsb      = addr_lsb(DATA_WIDTH);
  localparam int                    c_idx_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_lsb_mask = ADDR_WIDTH'((1 << c_lsb) - 1);
  localparam logic [ADDR_WIDTH-1:0] c_depth    = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            c_wait     = 4'(WAIT_STATES);

  state_t                    r_state;
  state_t                    w_next;
  logic [3:0]                r_cnt;
  logic [c_idx_w-1:0]        r_idx;
  logic                      r_err;
  logic                      r_write;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_strb;
  logic                      r_pready;
  logic                      r_pslverr;

  logic [ADDR_WIDTH-1:0]     w_word;
  logic                      w_err_live;
  logic [c_idx_w-1:0]        w_idx_live;
  logic                      w_capture;
  logic                      w_enter_ready;
  logic                      w_complete;
  logic                      w_leave_ready;
  logic [c_idx_w-1:0]        w_rd_idx;
  logic                      w_rd_err;
  logic                      w_rd_write;
  logic                      w_wr_en;
  logic                      w_rd_en;

  // Live decode of the bus address; high address bits take part in the range test
  assign w_word     = paddr >> c_lsb;
  assign w_err_live = ((paddr & c_lsb_mask) != '0) || (w_word >= c_depth);
  assign w_idx_live = w_word[c_idx_w-1:0];

  // Next-state and per-edge control decisions
  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_enter_ready = 1'b0;
    w_complete    = 1'b0;
    w_leave_ready = 1'b0;
    w_rd_idx      = r_idx;
    w_rd_err      = r_err;
    w_rd_write    = r_write;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_capture  = 1'b1;
          // A zero-wait slave enters READY on the setup edge, so use the live decode
          w_rd_idx   = w_idx_live;
          w_rd_err   = w_err_live;
          w_rd_write = pwrite;
          if (c_wait == 4'd0) begin
            w_next        = READY;
            w_enter_ready = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next        = READY;
          w_enter_ready = 1'b1;
        end
      end
      READY: begin
        if (!psel) begin
          w_next        = IDLE;
          w_leave_ready = 1'b1;
        end else if (penable) begin
          w_complete    = 1'b1;
          w_leave_ready = 1'b1;
          w_next        = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture at the setup edge and wait-state countdown
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_capture) begin
      r_cnt   <= c_wait;
      r_idx   <= w_idx_live;
      r_err   <= w_err_live;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered response flags: raised on READY entry, dropped when READY is left
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else if (w_enter_ready) begin
      r_pready  <= 1'b1;
      r_pslverr <= w_rd_err;
    end else if (w_leave_ready) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end
  end

  // Writes commit only on the completing edge; reads load on READY entry
  assign w_wr_en = w_complete && r_write && !r_err;
  assign w_rd_en = w_enter_ready && !w_rd_write;

  apb_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (c_idx_w)
  ) u_mem (
    .clk       (pclk),
    .rst_n     (presetn),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_wr_strb (r_strb),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .i_rd_zero (w_rd_err),
    .o_rd_data (prdata)
  );

  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_ram_wait.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_ram_wait
//  Purpose  : Self-checking bench for apb_ram_wait across four configurations
//             (zero-wait, three-wait, two-wait, 64-bit/20-deep).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_ram_wait;

  localparam int WS_OF    [4] = '{0, 3, 2, 1};
  localparam int NB_OF    [4] = '{4, 4, 4, 8};
  localparam int DEPTH_OF [4] = '{32, 32, 32, 20};

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [31:0] prdata0, prdata1, prdata2;
  logic [63:0] prdata3;
  logic [3:0]  pready, pslverr;

  always #5 pclk = ~pclk;

  apb_ram_wait #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_d0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
    .prdata(prdata0), .pready(pready[0]), .pslverr(pslverr[0]));
  apb_ram_wait #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_d1 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
    .prdata(prdata1), .pready(pready[1]), .pslverr(pslverr[1]));
  apb_ram_wait #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) u_d2 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
    .prdata(prdata2), .pready(pready[2]), .pslverr(pslverr[2]));
  apb_ram_wait #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(20), .WAIT_STATES(1)) u_d3 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[3]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready[3]), .pslverr(pslverr[3]));

  // Bench model: byte-addressed memory image and last-read value per instance
  logic [7:0]  mbytes [4][256];
  logic [63:0] model_prdata [4];

  // Transfer tracking shared between driver and compare process
  int          cur_k;
  bit          cur_wr;
  int          phase;     // 0 idle, 1 setup, 2 access
  int          acc_n;     // access-phase cycle number, 1-based
  logic        exp_err;
  logic [63:0] exp_rd;
  bit          mon_on;
  logic [63:0] obs_rdata;
  logic        obs_err;
  logic        exp_rdy;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [63:0] rd_of(input int k);
    case (k)
      0:       return {32'h0, prdata0};
      1:       return {32'h0, prdata1};
      2:       return {32'h0, prdata2};
      default: return prdata3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      model_prdata[k] = '0;
      for (int a = 0; a < 256; a++) mbytes[k][a] = 8'h00;
    end
  endtask

  // Cycle-by-cycle comparison of the selected instance against the model
  always @(negedge pclk) begin
    if (mon_on && presetn === 1'b1) begin
      exp_rdy = (phase == 2) && (acc_n == WS_OF[cur_k] + 1);
      chk("pready", {63'h0, pready[cur_k]}, {63'h0, exp_rdy});
      chk("pslverr", {63'h0, pslverr[cur_k]}, {63'h0, exp_rdy & exp_err});
      chk("prdata", rd_of(cur_k), (exp_rdy && !cur_wr) ? exp_rd : model_prdata[cur_k]);
      if (exp_rdy) begin
        obs_rdata = rd_of(cur_k);
        obs_err   = pslverr[cur_k];
      end
    end
  end

  // One APB transfer; starts just after a rising edge, ends just after the completing edge
  task automatic xfer(input int k, input bit wr, input logic [31:0] a,
                      input logic [63:0] d, input logic [7:0] s);
    int          nb;
    logic        e;
    logic [63:0] r;
    nb = NB_OF[k];
    e  = ((a % nb) != 0) || ((a / nb) >= DEPTH_OF[k]);
    r  = '0;
    if (!wr && !e)
      for (int b = 0; b < nb; b++) r[8*b +: 8] = mbytes[k][a + b];
    cur_k = k; cur_wr = wr; exp_err = e; exp_rd = r;
    obs_rdata = 'x; obs_err = 1'bx;
    psel = 4'b0; psel[k] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s; phase = 1;
    @(posedge pclk); #1;
    penable = 1'b1; phase = 2; acc_n = 1;
    for (int c = 1; c <= WS_OF[k] + 1; c++) begin
      @(posedge pclk);
      if (c == WS_OF[k] + 1) begin
        if (wr && !e)
          for (int b = 0; b < nb; b++) if (s[b]) mbytes[k][a + b] = d[8*b +: 8];
        if (!wr) model_prdata[k] = r;
        #1;
        psel = 4'b0; penable = 1'b0; phase = 0;
      end else begin
        #1;
        acc_n = c + 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    presetn = 1'b0; psel = 4'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    cur_k = 0; cur_wr = 1'b0; phase = 0; acc_n = 0; mon_on = 1'b0;
    exp_err = 1'b0; exp_rd = '0; exp_rdy = 1'b0; obs_rdata = '0; obs_err = 1'b0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_pready%0d", k), {63'h0, pready[k]}, 64'h0);
      chk($sformatf("rst_pslverr%0d", k), {63'h0, pslverr[k]}, 64'h0);
      chk($sformatf("rst_prdata%0d", k), rd_of(k), 64'h0);
    end
    presetn = 1'b1;
    mon_on  = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait write then read, back to back
    xfer(0, 1, 32'h00, 64'hA5A5A5A5, 8'hF);
    xfer(0, 1, 32'h08, 64'hDEADBEEF, 8'hF);
    xfer(0, 0, 32'h08, 64'h0, 8'h0);
    chk("rd08_data", obs_rdata, 64'hDEADBEEF);
    chk("rd08_err", {63'h0, obs_err}, 64'h0);

    // Byte strobes
    xfer(0, 1, 32'h04, 64'hFFFFFFFF, 8'hF);
    xfer(0, 1, 32'h04, 64'h00000000, 8'h5);
    xfer(0, 0, 32'h04, 64'h0, 8'h0);
    chk("strb_data", obs_rdata, 64'hFF00FF00);

    // Error responses: out of range, misaligned, high address bits
    xfer(0, 1, 32'h80, 64'h11111111, 8'hF);
    chk("wr80_err", {63'h0, obs_err}, 64'h1);
    xfer(0, 0, 32'h80, 64'h0, 8'h0);
    chk("rd80_err", {63'h0, obs_err}, 64'h1);
    chk("rd80_data", obs_rdata, 64'h0);
    xfer(0, 1, 32'h02, 64'h22222222, 8'hF);
    chk("wr02_err", {63'h0, obs_err}, 64'h1);
    xfer(0, 1, 32'h80000000, 64'h33333333, 8'hF);
    chk("wrhi_err", {63'h0, obs_err}, 64'h1);
    xfer(0, 0, 32'h00, 64'h0, 8'h0);
    chk("rd00_intact", obs_rdata, 64'hA5A5A5A5);
    chk("rd00_err", {63'h0, obs_err}, 64'h0);
    xfer(0, 0, 32'h08, 64'h0, 8'h0);
    chk("rd08_again", obs_rdata, 64'hDEADBEEF);

    // Three wait states
    xfer(1, 0, 32'h00, 64'h0, 8'h0);
    chk("ws3_rd00", obs_rdata, 64'h0);
    chk("ws3_err", {63'h0, obs_err}, 64'h0);
    xfer(1, 1, 32'h1C, 64'h0BADF00D, 8'hF);
    xfer(1, 0, 32'h1C, 64'h0, 8'h0);
    chk("ws3_rd1c", obs_rdata, 64'h0BADF00D);

    // 64-bit data, 20-word depth
    xfer(3, 1, 32'h98, 64'h0123456789ABCDEF, 8'hFF);
    chk("w64_98_err", {63'h0, obs_err}, 64'h0);
    xfer(3, 0, 32'h98, 64'h0, 8'h0);
    chk("w64_rd98", obs_rdata, 64'h0123456789ABCDEF);
    xfer(3, 1, 32'h98, 64'hFFFFFFFFFFFFFFFF, 8'hF0);
    xfer(3, 0, 32'h98, 64'h0, 8'h0);
    chk("w64_rd98_strb", obs_rdata, 64'hFFFFFFFF89ABCDEF);
    xfer(3, 1, 32'hA0, 64'h5A5A5A5A5A5A5A5A, 8'hFF);
    chk("w64_a0_err", {63'h0, obs_err}, 64'h1);
    xfer(3, 1, 32'h9C, 64'h5A5A5A5A5A5A5A5A, 8'hFF);
    chk("w64_9c_err", {63'h0, obs_err}, 64'h1);

    // Reset during the wait phase of a write
    xfer(2, 1, 32'h0C, 64'h1234, 8'hF);
    xfer(2, 0, 32'h0C, 64'h0, 8'h0);
    chk("ws2_rd0c", obs_rdata, 64'h1234);
    cur_k = 2; cur_wr = 1'b1; phase = 0;
    psel = 4'b0100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 64'h5555; pstrb = 8'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    presetn = 1'b0;
    model_reset();
    #1;
    chk("arst_pready", {63'h0, pready[2]}, 64'h0);
    chk("arst_pslverr", {63'h0, pslverr[2]}, 64'h0);
    chk("arst_prdata2", rd_of(2), 64'h0);
    chk("arst_prdata0", rd_of(0), 64'h0);
    psel = 4'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(2, 0, 32'h0C, 64'h0, 8'h0);
    chk("post_rst_rd0c", obs_rdata, 64'h0);
    xfer(0, 0, 32'h08, 64'h0, 8'h0);
    chk("post_rst_rd08", obs_rdata, 64'h0);

    repeat (2) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
